// File: rtl/inst_queue_pkg.sv
// Shared decode/issue types: the PC_set bundle and the default queue depth.
package Public_Info;

    localparam int IQ_DEPTH = 8;

    typedef struct packed {
        logic        o_valid;
        logic [31:0] PC;
        logic [31:0] inst;
    } PC_set;

endpackage

// File: rtl/inst_queue.sv
// Dual-issue instruction queue between decode and dispatch: circular buffer of PC_set entries.
// Optional performance counters are built only when INST_QUEUE_PERF_EN is defined.
module inst_queue
    import Public_Info::*;
#(
    parameter int DEPTH = IQ_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  PC_set       i_set1,
    input  PC_set       i_set2,
    input  logic [1:0]  i_valid,
    output logic        o_stall,
    output PC_set       o_set1,
    output PC_set       o_set2,
    output logic [1:0]  o_is_valid,
    input  logic [1:0]  i_usingNUM,
    output logic [31:0] o_full_cycles,
    output logic [31:0] o_empty_cycles
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    PC_set            mem_q [DEPTH];
    PC_set            mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;
    logic             push_en;
    logic [1:0]       push_num;
    logic [1:0]       pop_num;
    logic             illegal_pop;

    assign head_p1 = head_q + PTR_W'(1);
    assign tail_p1 = tail_q + PTR_W'(1);

    // Stall depends only on the registered count so fetch never sees a path from dispatch.
    assign o_stall    = count_q >= CNT_W'(DEPTH - 1);
    assign o_is_valid = {count_q >= CNT_W'(1), count_q >= CNT_W'(2)};

    always_comb begin
        o_set1         = mem_q[head_q];
        o_set2         = mem_q[head_p1];
        o_set1.o_valid = o_is_valid[1];
        o_set2.o_valid = o_is_valid[0];
    end

    assign push_en  = !o_stall && !flush;
    assign push_num = push_en ? ({1'b0, i_valid[1]} + {1'b0, i_valid[0]}) : 2'd0;

    always_comb begin
        illegal_pop = 1'b0;
        case (i_usingNUM)
            2'd0:    illegal_pop = 1'b0;
            2'd1:    illegal_pop = !o_is_valid[1];
            2'd2:    illegal_pop = !o_is_valid[0];
            default: illegal_pop = 1'b1;
        endcase
    end

    assign pop_num = illegal_pop ? 2'd0 : i_usingNUM;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        // A lone younger instruction is compacted into the tail slot to keep program order dense.
        if (push_en) begin
            case (i_valid)
                2'b11: begin
                    mem_d[tail_q]  = i_set1;
                    mem_d[tail_p1] = i_set2;
                end
                2'b10:   mem_d[tail_q] = i_set1;
                2'b01:   mem_d[tail_q] = i_set2;
                default: ;
            endcase
        end
    end

    always_comb begin
        head_d  = head_q + PTR_W'(pop_num);
        tail_d  = tail_q + PTR_W'(push_num);
        count_d = count_q + CNT_W'(push_num) - CNT_W'(pop_num);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage is never reset or cleared; only the count qualifies it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

`ifdef INST_QUEUE_PERF_EN
    logic [31:0] full_cycles_q, full_cycles_d;
    logic [31:0] empty_cycles_q, empty_cycles_d;

    always_comb begin
        full_cycles_d  = full_cycles_q;
        empty_cycles_d = empty_cycles_q;
        if (o_stall && (full_cycles_q != '1)) begin
            full_cycles_d = full_cycles_q + 32'd1;
        end
        if ((count_q == '0) && (empty_cycles_q != '1)) begin
            empty_cycles_d = empty_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_cycles_q  <= '0;
            empty_cycles_q <= '0;
        end else begin
            full_cycles_q  <= full_cycles_d;
            empty_cycles_q <= empty_cycles_d;
        end
    end

    assign o_full_cycles  = full_cycles_q;
    assign o_empty_cycles = empty_cycles_q;
`else
    assign o_full_cycles  = 32'd0;
    assign o_empty_cycles = 32'd0;
`endif

`ifndef SYNTHESIS
    // Dispatch must never consume more entries than are presented.
    illegal_pop_check: assert property (@(posedge clk) disable iff (rst) !illegal_pop);
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue: push/pop ordering, stall, wrap, flush, reset and perf counters.
module tb_inst_queue;
    import Public_Info::*;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        flush;
    PC_set       i_set1;
    PC_set       i_set2;
    logic [1:0]  i_valid;
    logic        o_stall;
    PC_set       o_set1;
    PC_set       o_set2;
    logic [1:0]  o_is_valid;
    logic [1:0]  i_usingNUM;
    logic [31:0] o_full_cycles;
    logic [31:0] o_empty_cycles;

    int checks;
    int failures;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .i_set1        (i_set1),
        .i_set2        (i_set2),
        .i_valid       (i_valid),
        .o_stall       (o_stall),
        .o_set1        (o_set1),
        .o_set2        (o_set2),
        .o_is_valid    (o_is_valid),
        .i_usingNUM    (i_usingNUM),
        .o_full_cycles (o_full_cycles),
        .o_empty_cycles(o_empty_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic PC_set make_set(input logic [31:0] pc);
        PC_set s;
        s.o_valid = 1'b1;
        s.PC      = pc;
        s.inst    = pc ^ 32'hA5A5_0000;
        return s;
    endfunction

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush      = 1'b0;
        i_valid    = 2'b00;
        i_usingNUM = 2'd0;
        i_set1     = make_set(32'h0);
        i_set2     = make_set(32'h0);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (o_is_valid !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_valid: got %b expected 00", o_is_valid);
        end
        checks++;
        if (o_stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_stall: got %b expected 0", o_stall);
        end
        checks++;
        if (o_full_cycles !== 32'd0 || o_empty_cycles !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", o_full_cycles, o_empty_cycles);
        end
        // Push a pair, then reset asynchronously between edges.
        i_set1  = make_set(32'h0000_0400);
        i_set2  = make_set(32'h0000_0404);
        i_valid = 2'b11;
        step();
        idle_inputs();
        checks++;
        if (o_is_valid !== 2'b11) begin
            failures++;
            $display("[TB] FAIL pre_async_valid: got %b expected 11", o_is_valid);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (o_is_valid !== 2'b00) begin
            failures++;
            $display("[TB] FAIL async_reset_valid: got %b expected 00", o_is_valid);
        end
        rst = 1'b0;
        step();
        checks++;
        if (o_is_valid !== 2'b00) begin
            failures++;
            $display("[TB] FAIL after_reset_empty: got %b expected 00", o_is_valid);
        end
    endtask

    task automatic test_push_two();
        i_set1  = make_set(32'h1c00_0000);
        i_set2  = make_set(32'h1c00_0004);
        i_valid = 2'b11;
        step();
        idle_inputs();
        checks++;
        if (o_is_valid !== 2'b11) begin
            failures++;
            $display("[TB] FAIL push2_valid: got %b expected 11", o_is_valid);
        end
        checks++;
        if (o_set1.PC !== 32'h1c00_0000 || o_set1.o_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL push2_set1: got %h/%b expected 1c000000/1", o_set1.PC, o_set1.o_valid);
        end
        checks++;
        if (o_set2.PC !== 32'h1c00_0004 || o_set2.inst !== (32'h1c00_0004 ^ 32'hA5A5_0000)) begin
            failures++;
            $display("[TB] FAIL push2_set2: got %h/%h expected 1c000004/%h", o_set2.PC, o_set2.inst,
                     32'h1c00_0004 ^ 32'hA5A5_0000);
        end
        i_usingNUM = 2'd2;
        step();
        idle_inputs();
        checks++;
        if (o_is_valid !== 2'b00) begin
            failures++;
            $display("[TB] FAIL push2_drain: got %b expected 00", o_is_valid);
        end
    endtask

    task automatic test_single();
        i_set1  = make_set(32'hdead_0000);
        i_set2  = make_set(32'h0000_0020);
        i_valid = 2'b01;
        step();
        idle_inputs();
        checks++;
        if (o_set1.PC !== 32'h0000_0020) begin
            failures++;
            $display("[TB] FAIL single_pc: got %h expected 00000020", o_set1.PC);
        end
        checks++;
        if (o_is_valid !== 2'b10 || o_set2.o_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_valid: got %b/%b expected 10/0", o_is_valid, o_set2.o_valid);
        end
        i_usingNUM = 2'd1;
        step();
        idle_inputs();
        checks++;
        if (o_is_valid !== 2'b00) begin
            failures++;
            $display("[TB] FAIL single_drain: got %b expected 00", o_is_valid);
        end
    endtask

    task automatic test_full();
        logic [31:0] exp1;
        for (int k = 0; k < 3; k++) begin
            i_set1  = make_set(32'h100 + 32'(8 * k));
            i_set2  = make_set(32'h104 + 32'(8 * k));
            i_valid = 2'b11;
            step();
        end
        i_set1  = make_set(32'h118);
        i_valid = 2'b10;
        step();
        idle_inputs();
        checks++;
        if (o_stall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL full_stall: got %b expected 1", o_stall);
        end
        // Push while stalled must be dropped.
        i_set1  = make_set(32'h200);
        i_set2  = make_set(32'h204);
        i_valid = 2'b11;
        step();
        checks++;
        if (o_stall !== 1'b1 || o_set1.PC !== 32'h100) begin
            failures++;
            $display("[TB] FAIL full_ignore: got %b/%h expected 1/00000100", o_stall, o_set1.PC);
        end
        i_usingNUM = 2'd1;
        step();
        idle_inputs();
        checks++;
        if (o_stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_pop_unstall: got %b expected 0", o_stall);
        end
        for (int k = 0; k < 3; k++) begin
            exp1 = 32'h104 + 32'(8 * k);
            checks++;
            if (o_set1.PC !== exp1 || o_set2.PC !== exp1 + 32'd4 || o_is_valid !== 2'b11) begin
                failures++;
                $display("[TB] FAIL full_drain_%0d: got %h/%h/%b expected %h/%h/11", k,
                         o_set1.PC, o_set2.PC, o_is_valid, exp1, exp1 + 32'd4);
            end
            i_usingNUM = 2'd2;
            step();
            idle_inputs();
        end
        checks++;
        if (o_is_valid !== 2'b00) begin
            failures++;
            $display("[TB] FAIL full_empty: got %b expected 00", o_is_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp1;
        i_set1  = make_set(32'h1000);
        i_set2  = make_set(32'h1004);
        i_valid = 2'b11;
        step();
        for (int k = 0; k < 3 * DEPTH; k++) begin
            exp1 = 32'h1000 + 32'(8 * k);
            checks++;
            if (o_set1.PC !== exp1 || o_set2.PC !== exp1 + 32'd4 || o_is_valid !== 2'b11 || o_stall !== 1'b0) begin
                failures++;
                $display("[TB] FAIL wrap_%0d: got %h/%h/%b/%b expected %h/%h/11/0", k,
                         o_set1.PC, o_set2.PC, o_is_valid, o_stall, exp1, exp1 + 32'd4);
            end
            i_set1     = make_set(exp1 + 32'd8);
            i_set2     = make_set(exp1 + 32'd12);
            i_valid    = 2'b11;
            i_usingNUM = 2'd2;
            step();
        end
        idle_inputs();
        i_usingNUM = 2'd2;
        step();
        idle_inputs();
        checks++;
        if (o_is_valid !== 2'b00) begin
            failures++;
            $display("[TB] FAIL wrap_empty: got %b expected 00", o_is_valid);
        end
    endtask

    task automatic test_flush();
        i_set1  = make_set(32'h3000);
        i_set2  = make_set(32'h3004);
        i_valid = 2'b11;
        step();
        step();
        i_valid = 2'b10;
        step();
        flush      = 1'b1;
        i_valid    = 2'b11;
        i_usingNUM = 2'd1;
        step();
        idle_inputs();
        checks++;
        if (o_is_valid !== 2'b00 || o_stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_empty: got %b/%b expected 00/0", o_is_valid, o_stall);
        end
        i_set1  = make_set(32'h3100);
        i_valid = 2'b10;
        step();
        idle_inputs();
        checks++;
        if (o_set1.PC !== 32'h3100 || o_is_valid !== 2'b10) begin
            failures++;
            $display("[TB] FAIL flush_refill: got %h/%b expected 00003100/10", o_set1.PC, o_is_valid);
        end
        i_usingNUM = 2'd1;
        step();
        idle_inputs();
    endtask

    task automatic test_perf();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            i_set1  = make_set(32'h5000 + 32'(8 * k));
            i_set2  = make_set(32'h5004 + 32'(8 * k));
            i_valid = 2'b11;
            step();
        end
        idle_inputs();
        for (int k = 0; k < 10; k++) begin
            step();
        end
`ifdef INST_QUEUE_PERF_EN
        checks++;
        if (o_full_cycles !== 32'd10) begin
            failures++;
            $display("[TB] FAIL perf_full: got %0d expected 10", o_full_cycles);
        end
        checks++;
        if (o_empty_cycles !== 32'd1) begin
            failures++;
            $display("[TB] FAIL perf_empty: got %0d expected 1", o_empty_cycles);
        end
`else
        checks++;
        if (o_full_cycles !== 32'd0 || o_empty_cycles !== 32'd0) begin
            failures++;
            $display("[TB] FAIL perf_off: got %0d/%0d expected 0/0", o_full_cycles, o_empty_cycles);
        end
`endif
        do_reset();
        checks++;
        if (o_is_valid !== 2'b00 || o_stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midstream_reset: got %b/%b expected 00/0", o_is_valid, o_stall);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_push_two();
        test_single();
        test_full();
        test_back_to_back();
        test_flush();
        test_perf();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
